// File: rtl/calyx_run_pkg.sv
// Shared types and helpers for the Calyx go/done run controller.
package calyx_run_pkg;

    localparam int unsigned RESET_CYCLES_DEF = 3;
    localparam int unsigned SAT_W            = 64;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        RUN,
        GAP,
        FIN
    } run_state_e;

    // Unsigned add clamped to the all-ones value of a w-bit counter (w <= SAT_W).
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input int unsigned      w);
        logic [SAT_W:0] sum;
        logic [SAT_W:0] sat_max;
        sat_max = {1'b0, {SAT_W{1'b1}} >> (SAT_W - w)};
        sum     = {1'b0, a} + {1'b0, b};
        return (sum > sat_max) ? sat_max[SAT_W-1:0] : sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/calyx_run_ctrl_if.sv
// go/done handshake bundle between the run controller and the Calyx components.
interface calyx_run_ctrl_if #(
    parameter int unsigned NUM_CH = 1
);
    logic              dut_reset;
    logic [NUM_CH-1:0] dut_go;
    logic [NUM_CH-1:0] dut_done;

    modport master (output dut_reset, output dut_go, input dut_done);
    modport slave  (input dut_reset, input dut_go, output dut_done);
endinterface

// File: rtl/calyx_run_chan.sv
// One go/done channel: drives go, tracks completion and captures latency.
module calyx_run_chan
    import calyx_run_pkg::*;
#(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             run_start,
    input  logic             abort,
    input  logic [CNT_W-1:0] k,
    input  logic [CNT_W-1:0] limit,
    input  logic             done,
    output logic             go,
    output logic             complete,
    output logic             hit_c,
    output logic [CNT_W-1:0] cycles
);

    logic [CNT_W-1:0] k_inc;

    assign k_inc = CNT_W'(sat_add(SAT_W'(k), SAT_W'(1), CNT_W));

    // done only counts while go is high; later done levels are ignored.
    assign hit_c = go & done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            go       <= 1'b0;
            complete <= 1'b0;
            cycles   <= '0;
        end else begin
            if (run_start) begin
                go       <= 1'b1;
                complete <= 1'b0;
            end else if (hit_c) begin
                go       <= 1'b0;
                complete <= 1'b1;
                cycles   <= k_inc;
            end else if (abort && go) begin
                go       <= 1'b0;
                complete <= 1'b1;
                cycles   <= limit;
            end
            if (clr) begin
                cycles <= '0;
            end
        end
    end

endmodule

// File: rtl/calyx_run_ctrl.sv
// Run controller for Calyx go/done components: reset window, repeated runs,
// per-channel latency capture, cycle limit and session status.
module calyx_run_ctrl
    import calyx_run_pkg::*;
#(
    parameter int unsigned NUM_CH       = 1,
    parameter int unsigned CNT_W        = 64,
    parameter int unsigned RUN_W        = 16,
    parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [CNT_W-1:0]        cycle_limit,
    input  logic [RUN_W-1:0]        num_runs,
    calyx_run_ctrl_if.master        bus,
    output logic                    busy,
    output logic                    finished,
    output logic                    timeout,
    output logic [RUN_W-1:0]        run_idx,
    output logic [NUM_CH*CNT_W-1:0] ch_cycles,
    output logic [CNT_W-1:0]        total_cycles
);

    localparam int unsigned RC_W = $clog2(RESET_CYCLES + 1);

    run_state_e        state, state_n;
    logic [RC_W-1:0]   rst_cnt;
    logic [CNT_W-1:0]  k;
    logic [CNT_W-1:0]  k_inc;
    logic [CNT_W-1:0]  limit_q;
    logic [RUN_W-1:0]  runs_q;
    logic              dut_reset_q;

    logic              clr_c;
    logic              run_start_c;
    logic              run_done_c;
    logic              abort_c;
    logic              next_run_c;
    logic              all_done_c;

    logic [NUM_CH-1:0] go_w;
    logic [NUM_CH-1:0] complete_w;
    logic [NUM_CH-1:0] hit_w;

    assign k_inc         = CNT_W'(sat_add(SAT_W'(k), SAT_W'(1), CNT_W));
    assign all_done_c    = &(complete_w | hit_w);
    assign bus.dut_go    = go_w;
    assign bus.dut_reset = dut_reset_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        clr_c       = 1'b0;
        run_start_c = 1'b0;
        run_done_c  = 1'b0;
        abort_c     = 1'b0;
        next_run_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr_c   = 1'b1;
                    state_n = RST;
                end
            end
            RST: begin
                if (rst_cnt == RC_W'(RESET_CYCLES - 1)) begin
                    run_start_c = 1'b1;
                    state_n     = RUN;
                end
            end
            RUN: begin
                // Completion takes priority over a limit hit in the same cycle.
                if (all_done_c) begin
                    run_done_c = 1'b1;
                    state_n    = GAP;
                end else if ((limit_q != '0) && (k_inc == limit_q)) begin
                    abort_c = 1'b1;
                    state_n = FIN;
                end
            end
            GAP: begin
                if (run_idx < (runs_q - RUN_W'(1))) begin
                    next_run_c  = 1'b1;
                    run_start_c = 1'b1;
                    state_n     = RUN;
                end else begin
                    state_n = FIN;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Status outputs are registered decodes of the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy        <= 1'b0;
            finished    <= 1'b0;
            dut_reset_q <= 1'b1;
        end else begin
            busy        <= (state_n != IDLE);
            finished    <= (state_n == FIN);
            dut_reset_q <= (state_n == IDLE) || (state_n == RST) || (state_n == FIN);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt      <= '0;
            k            <= '0;
            limit_q      <= '0;
            runs_q       <= '0;
            run_idx      <= '0;
            timeout      <= 1'b0;
            total_cycles <= '0;
        end else begin
            if (clr_c) begin
                rst_cnt      <= '0;
                limit_q      <= cycle_limit;
                runs_q       <= (num_runs == '0) ? RUN_W'(1) : num_runs;
                run_idx      <= '0;
                timeout      <= 1'b0;
                total_cycles <= '0;
            end else if (state == RST) begin
                rst_cnt <= rst_cnt + RC_W'(1);
            end
            if (run_start_c) begin
                k <= '0;
            end else if (state == RUN) begin
                k <= k_inc;
            end
            if (next_run_c) begin
                run_idx <= run_idx + RUN_W'(1);
            end
            // The slowest channel finishes last, so k+1 here is the run maximum.
            if (run_done_c) begin
                total_cycles <= CNT_W'(sat_add(SAT_W'(total_cycles), SAT_W'(k_inc), CNT_W));
            end
            if (abort_c) begin
                timeout <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        calyx_run_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .clr       (clr_c),
            .run_start (run_start_c),
            .abort     (abort_c),
            .k         (k),
            .limit     (limit_q),
            .done      (bus.dut_done[i]),
            .go        (go_w[i]),
            .complete  (complete_w[i]),
            .hit_c     (hit_w[i]),
            .cycles    (ch_cycles[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_calyx_run_ctrl.sv
// Directed bench for calyx_run_ctrl: vector table of sessions plus hand sequences.
module tb_calyx_run_ctrl;

    localparam int unsigned NCH = 3;
    localparam int unsigned CW  = 8;
    localparam int unsigned RW  = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [CW-1:0]   cycle_limit;
    logic [RW-1:0]   num_runs;
    logic            busy;
    logic            finished;
    logic            timeout;
    logic [RW-1:0]   run_idx;
    logic [NCH*CW-1:0] ch_cycles;
    logic [CW-1:0]   total_cycles;

    calyx_run_ctrl_if #(.NUM_CH(NCH)) bus ();

    calyx_run_ctrl #(
        .NUM_CH       (NCH),
        .CNT_W        (CW),
        .RUN_W        (RW),
        .RESET_CYCLES (3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .cycle_limit  (cycle_limit),
        .num_runs     (num_runs),
        .bus          (bus),
        .busy         (busy),
        .finished     (finished),
        .timeout      (timeout),
        .run_idx      (run_idx),
        .ch_cycles    (ch_cycles),
        .total_cycles (total_cycles)
    );

    always #5 clk = ~clk;

    // Component model: done on the lat-th cycle go is high (lat 0 = never);
    // with hold_en the done level stays high after go drops until next start.
    int               lat  [NCH];
    int               gcnt [NCH];
    logic             hold_en;
    logic [NCH-1:0]   dhold = '0;
    logic [NCH-1:0]   done_w;

    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            gcnt[i] <= bus.dut_go[i] ? gcnt[i] + 1 : 0;
            if (!reset_n || start) dhold[i] <= 1'b0;
            else if (hold_en && bus.dut_go[i] && done_w[i]) dhold[i] <= 1'b1;
        end
    end

    always_comb begin
        done_w = '0;
        for (int i = 0; i < NCH; i++) begin
            done_w[i] = dhold[i] | (bus.dut_go[i] && (lat[i] != 0) && (gcnt[i] == lat[i] - 1));
        end
    end

    assign bus.dut_done = done_w;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        int runs; int limit;
        int lat0; int lat1; int lat2; int hold;
        int ch0;  int ch1;  int ch2;
        int total; int to; int idx; int rises;
    } vec_t;

    vec_t vecs [12];

    task automatic run_vec(input vec_t v, input int id);
        int  lat_v [NCH];
        int  cur [NCH];
        int  go_len [NCH];
        int  exp_ch [NCH];
        int  exp_go;
        int  rst_hi, rises, gap, max_gap, cyc;
        bit  seen_go, prev_any, rst_in_run, got_fin;
        lat_v  = '{v.lat0, v.lat1, v.lat2};
        exp_ch = '{v.ch0, v.ch1, v.ch2};
        for (int i = 0; i < NCH; i++) begin
            lat[i] = lat_v[i]; cur[i] = 0; go_len[i] = 0;
        end
        hold_en     = (v.hold != 0);
        num_runs    = RW'(v.runs);
        cycle_limit = CW'(v.limit);
        rst_hi = 0; rises = 0; gap = 0; max_gap = 0; cyc = 0;
        seen_go = 0; prev_any = 0; rst_in_run = 0; got_fin = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!got_fin && cyc < 3000) begin
            if (!seen_go && bus.dut_reset) rst_hi++;
            if (|bus.dut_go) begin
                if (!prev_any) begin
                    rises++;
                    if (seen_go && gap > max_gap) max_gap = gap;
                end
                seen_go = 1; gap = 0;
            end else if (seen_go) begin
                gap++;
            end
            prev_any = |bus.dut_go;
            for (int i = 0; i < NCH; i++) begin
                if (bus.dut_go[i]) cur[i]++;
                else if (cur[i] != 0) begin go_len[i] = cur[i]; cur[i] = 0; end
            end
            if (seen_go && !finished && bus.dut_reset) rst_in_run = 1;
            if (finished) got_fin = 1;
            else begin @(negedge clk); cyc++; end
        end
        chk($sformatf("v%0d_finished_seen", id), 64'(got_fin), 64'd1);
        chk($sformatf("v%0d_reset_window", id), 64'(rst_hi), 64'd3);
        chk($sformatf("v%0d_run_starts", id), 64'(rises), 64'(v.rises));
        chk($sformatf("v%0d_gap_len", id), 64'(max_gap), (v.rises > 1) ? 64'd1 : 64'd0);
        chk($sformatf("v%0d_no_reset_in_run", id), 64'(rst_in_run), 64'd0);
        for (int i = 0; i < NCH; i++) begin
            exp_go = (lat_v[i] != 0 && (v.limit == 0 || lat_v[i] <= v.limit)) ? lat_v[i] : v.limit;
            chk($sformatf("v%0d_ch%0d_cycles", id, i), 64'(ch_cycles[i*CW +: CW]), 64'(exp_ch[i]));
            chk($sformatf("v%0d_ch%0d_go_len", id, i), 64'(go_len[i]), 64'(exp_go));
        end
        chk($sformatf("v%0d_total", id), 64'(total_cycles), 64'(v.total));
        chk($sformatf("v%0d_timeout", id), 64'(timeout), 64'(v.to));
        chk($sformatf("v%0d_run_idx", id), 64'(run_idx), 64'(v.idx));
        chk($sformatf("v%0d_busy_at_fin", id), 64'(busy), 64'd1);
        @(negedge clk);
        chk($sformatf("v%0d_busy_after", id), 64'(busy), 64'd0);
        chk($sformatf("v%0d_finished_pulse", id), 64'(finished), 64'd0);
        chk($sformatf("v%0d_dut_reset_after", id), 64'(bus.dut_reset), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_dut_reset"}, 64'(bus.dut_reset), 64'd1);
        chk({tag, "_go"}, 64'(bus.dut_go), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_finished"}, 64'(finished), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        chk({tag, "_run_idx"}, 64'(run_idx), 64'd0);
        chk({tag, "_ch_cycles"}, 64'(ch_cycles), 64'd0);
        chk({tag, "_total"}, 64'(total_cycles), 64'd0);
    endtask

    initial begin
        int cyc;
        //             runs lim lat0 lat1 lat2 hold ch0  ch1  ch2 total to idx rises
        vecs[0]  = '{1,  0,   5,   5,   5,  0,   5,   5,   5,   5, 0, 0, 1};
        vecs[1]  = '{1,  0,   2,   7,   4,  1,   2,   7,   4,   7, 0, 0, 1};
        vecs[2]  = '{3,  0,   6,   6,   6,  0,   6,   6,   6,  18, 0, 2, 3};
        vecs[3]  = '{1, 10,   0,   0,   0,  0,  10,  10,  10,   0, 1, 0, 1};
        vecs[4]  = '{1, 10,  10,  10,  10,  0,  10,  10,  10,  10, 0, 0, 1};
        vecs[5]  = '{0,  0,   3,   3,   3,  0,   3,   3,   3,   3, 0, 0, 1};
        vecs[6]  = '{1, 10,   3,  10,   0,  0,   3,  10,  10,   0, 1, 0, 1};
        vecs[7]  = '{3,  5,   7,   7,   7,  0,   5,   5,   5,   0, 1, 0, 1};
        vecs[8]  = '{2,  0, 200, 200, 200,  0, 200, 200, 200, 255, 0, 1, 2};
        vecs[9]  = '{1,  0, 300, 300, 300,  0, 255, 255, 255, 255, 0, 0, 1};
        vecs[10] = '{1,  1,   1,   1,   1,  0,   1,   1,   1,   1, 0, 0, 1};
        vecs[11] = '{2,  4,   2,   3,   4,  0,   2,   3,   4,   8, 0, 1, 2};

        reset_n = 1'b0; start = 1'b0; cycle_limit = '0; num_runs = '0; hold_en = 1'b0;
        for (int i = 0; i < NCH; i++) lat[i] = 0;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 12; v++) run_vec(vecs[v], v);

        // Start while busy must be ignored; reset mid-RUN must clear everything at once.
        for (int i = 0; i < NCH; i++) lat[i] = 4;
        hold_en = 1'b0; num_runs = RW'(3); cycle_limit = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(|bus.dut_go) && cyc < 50) begin @(negedge clk); cyc++; end
        chk("midrst_go_seen", 64'(|bus.dut_go), 64'd1);
        num_runs = RW'(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_ignored_busy", 64'(busy), 64'd1);
        chk("busy_start_ignored_rst0", 64'(bus.dut_reset), 64'd0);
        @(negedge clk);
        chk("busy_start_ignored_rst1", 64'(bus.dut_reset), 64'd0);
        cyc = 0;
        while (!(run_idx == RW'(1) && |bus.dut_go) && cyc < 50) begin @(negedge clk); cyc++; end
        chk("midrst_run_idx", 64'(run_idx), 64'd1);
        chk("midrst_total_before", 64'(total_cycles), 64'd4);
        chk("midrst_ch0_before", 64'(ch_cycles[0 +: CW]), 64'd4);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_vec(vecs[5], 12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/calyx_run_ctrl.md
Name: calyx_run_ctrl

Overview:
- Synthesizable run controller for Calyx `main`-style components that use the go/done protocol.
- Sequences the DUT reset window, drives `go` on NUM_CH independent component instances and measures per-channel latency.
- Repeats the run NUM_RUNS times, enforces an optional cycle limit and reports status registers.
- Sits between the FPGA/emulation host interface and the instantiated Calyx components; replaces free-running simulation-only harness logic.

Parameters:
- NUM_CH, 1, number of independent go/done channels (1..32).
- CNT_W, 64, width of cycle counters and cycle_limit.
- RUN_W, 16, width of run count and run index.
- RESET_CYCLES, 3, cycles dut_reset is held high after start (>=1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset of this block.
- start  in  1  single-cycle pulse; begins a session when idle.
- cycle_limit  in  CNT_W  per-run limit; 0 = unlimited; sampled at start.
- num_runs  in  RUN_W  runs per session; 0 treated as 1; sampled at start.
- dut_reset  out  1  active-high synchronous reset to the Calyx components.
- dut_go  out  NUM_CH  per-channel go.
- dut_done  in  NUM_CH  per-channel done.
- busy  out  1  session in progress.
- finished  out  1  one-cycle pulse at session end (success or timeout).
- timeout  out  1  sticky; set when a run hit the limit, cleared at next start.
- run_idx  out  RUN_W  index of the current/last run (0-based).
- ch_cycles  out  NUM_CH*CNT_W  latency of the last completed run per channel; channel i occupies bits [i*CNT_W +: CNT_W].
- total_cycles  out  CNT_W  sum over completed runs of the max channel latency; saturates.

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE; dut_reset=1; dut_go=0; busy=0; finished=0; timeout=0; run_idx=0; ch_cycles=0; total_cycles=0.
- IDLE:
  - dut_reset=1, dut_go=0.
  - start=1 latches limit and runs, clears timeout/total_cycles/ch_cycles/run_idx, sets busy, then goes to RST.
- RST:
  - dut_reset=1 for exactly RESET_CYCLES cycles, then RUN.
  - dut_reset=0 from the first RUN cycle.
- RUN:
  - On entry, dut_go=all ones and run counter k=0; k increments each RUN cycle.
  - done[i] sampled high while go[i]=1 means ch_cycles[i]=k+1 (count of cycles go[i] was high, inclusive of the done cycle).
  - go[i] drops on the next cycle and that channel is marked complete.
  - done[i] while go[i]=0 is ignored.
- Run completion: when all channels are complete, go to GAP.
  - total_cycles += max(ch_cycles) of this run.
- GAP:
  - One cycle with all go=0 so single-cycle done pulses are not re-seen.
  - If run_idx+1 < runs: run_idx++ and go to RUN, with no DUT reset.
  - Otherwise go to FIN.
- Timeout: if limit!=0 and k+1==limit in RUN with channels still incomplete:
  - All go drop next cycle; timeout=1; state goes to FIN.
  - Incomplete channels report ch_cycles=limit.
  - total_cycles is not updated for that run.
- Simultaneous last done and limit in the same cycle: completion wins, timeout stays 0.
- FIN:
  - finished=1 for one cycle; busy drops next cycle; dut_reset=1 again; then IDLE.
- start while busy is ignored.
- Counters saturate at 2^CNT_W-1.
- Reset mid-session aborts immediately to the reset values above.

Decomposition:
- Package calyx_run_pkg:
  - state enum (IDLE, RST, RUN, GAP, FIN).
  - sat_add function.
  - RESET_CYCLES default constant.
- Sub-module calyx_run_chan:
  - One per channel, generated NUM_CH times.
  - Owns go[i], the complete flag and the ch_cycles[i] capture.
  - Inputs: run-start pulse, abort pulse, k, limit.

Test Plan:
- NUM_CH=1, runs=1, limit=0, done on 5th go cycle -> dut_reset high 3 cycles; ch_cycles=5; total=5; finished pulse; timeout=0.
- NUM_CH=3, done at go-cycles 2/7/4 -> each go drops the cycle after its done; ch_cycles={4,7,2} (ch2,ch1,ch0); total=7.
- runs=3, latency 6 every run -> go low exactly one cycle between runs; no dut_reset between runs; run_idx ends 2; total=18.
- limit=10, DUT never done -> go drops after 10th cycle; timeout=1; ch_cycles=10; total=0; finished pulse.
- limit=10, done on 10th cycle -> timeout=0; ch_cycles=10; total=10.
- reset_n low mid-RUN, start during busy, num_runs=0 -> outputs at reset values at once; start while busy ignored; num_runs=0 runs once.
